// File: rtl/mo_line_writer.sv
// Motion object line writer: scans object RAM during hblank and writes
// matching objects' pixels into the line buffer.
module mo_line_writer #(
    parameter int NOBJ = 40
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        START,
    input  logic        PLAYER2,
    output logic [6:0]  OBJA,
    input  logic [15:0] OBJD,
    output logic [15:0] SR,
    input  logic        MATCHn,
    input  logic [3:0]  ROW,
    output logic [13:0] GA,
    input  logic [7:0]  GD,
    output logic [7:0]  LBADDR,
    output logic [7:0]  LBDATA,
    output logic        LBWE,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [5:0] LAST = 6'(NOBJ - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_A0,
        S_D0,
        S_W,
        S_CHK,
        S_A1,
        S_D1,
        S_GADR,
        S_GDAT,
        S_PHI,
        S_PLO
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  n_q, n_d;
    logic [1:0]  k_q, k_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  col_q, col_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  gd_q, gd_d;
    logic [15:0] sr_q, sr_d;
    logic [6:0]  obja_q, obja_d;
    logic [13:0] ga_q, ga_d;
    logic [7:0]  lbaddr_q, lbaddr_d;
    logic [7:0]  lbdata_q, lbdata_d;
    logic        lbwe_q, lbwe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        next_obj;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [3:0]  wr_nib;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        k_d      = k_q;
        row_d    = row_q;
        col_d    = col_q;
        x_d      = x_q;
        gd_d     = gd_q;
        sr_d     = sr_q;
        obja_d   = obja_q;
        ga_d     = ga_q;
        lbaddr_d = lbaddr_q;
        lbdata_d = lbdata_q;
        lbwe_d   = 1'b0;
        done_d   = 1'b0;
        busy_d   = busy_q;
        next_obj = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = 3'd0;
        wr_nib   = 4'd0;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    n_d     = 6'd0;
                    obja_d  = 7'd0;
                    state_d = S_A0;
                end
            end
            S_A0: state_d = S_D0;
            S_D0: begin
                sr_d    = OBJD;
                state_d = S_W;
            end
            S_W: state_d = S_CHK;
            S_CHK: begin
                if (MATCHn) begin
                    next_obj = 1'b1;
                end else begin
                    row_d   = ROW;
                    k_d     = 2'd0;
                    obja_d  = {n_q, 1'b1};
                    state_d = S_A1;
                end
            end
            S_A1: state_d = S_D1;
            S_D1: begin
                col_d   = OBJD[11:8];
                x_d     = OBJD[7:0];
                ga_d    = {sr_q[7:0], row_q, k_q};
                state_d = S_GADR;
            end
            S_GADR: state_d = S_GDAT;
            S_GDAT: begin
                // High nibble goes out straight from the ROM bus
                gd_d    = GD;
                wr_en   = 1'b1;
                wr_idx  = {k_q, 1'b0};
                wr_nib  = GD[7:4];
                state_d = S_PHI;
            end
            S_PHI: begin
                wr_en   = 1'b1;
                wr_idx  = {k_q, 1'b1};
                wr_nib  = gd_q[3:0];
                state_d = S_PLO;
            end
            S_PLO: begin
                if (k_q != 2'd3) begin
                    k_d     = k_q + 2'd1;
                    ga_d    = {sr_q[7:0], row_q, k_q + 2'd1};
                    state_d = S_GADR;
                end else begin
                    next_obj = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (next_obj) begin
            if (n_q == LAST) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                n_d     = n_q + 6'd1;
                obja_d  = {n_q + 6'd1, 1'b0};
                state_d = S_A0;
            end
        end

        if (wr_en) begin
            lbdata_d = {col_q, wr_nib};
            lbwe_d   = |wr_nib;
            lbaddr_d = PLAYER2 ? x_q + (8'd7 - {5'd0, wr_idx})
                               : x_q + {5'd0, wr_idx};
        end

        // Restart wins over everything, including a final DONE
        if (START && state_q != S_IDLE) begin
            state_d = S_A0;
            n_d     = 6'd0;
            obja_d  = 7'd0;
            lbwe_d  = 1'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= S_IDLE;
            n_q      <= 6'd0;
            k_q      <= 2'd0;
            row_q    <= 4'd0;
            col_q    <= 4'd0;
            x_q      <= 8'd0;
            gd_q     <= 8'd0;
            sr_q     <= 16'd0;
            obja_q   <= 7'd0;
            ga_q     <= 14'd0;
            lbaddr_q <= 8'd0;
            lbdata_q <= 8'd0;
            lbwe_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            k_q      <= k_d;
            row_q    <= row_d;
            col_q    <= col_d;
            x_q      <= x_d;
            gd_q     <= gd_d;
            sr_q     <= sr_d;
            obja_q   <= obja_d;
            ga_q     <= ga_d;
            lbaddr_q <= lbaddr_d;
            lbdata_q <= lbdata_d;
            lbwe_q   <= lbwe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign OBJA   = obja_q;
    assign SR     = sr_q;
    assign GA     = ga_q;
    assign LBADDR = lbaddr_q;
    assign LBDATA = lbdata_q;
    assign LBWE   = lbwe_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_mo_line_writer.sv
// Bench for mo_line_writer: RAM/ROM/vertical-control models plus
// scoreboards for line buffer writes, ROM addresses and object addresses.
module tb_mo_line_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        player2 = 1'b0;
    logic [6:0]  obja;
    logic [15:0] objd = 16'd0;
    logic [15:0] sr;
    logic        matchn = 1'b1;
    logic [3:0]  row = 4'd0;
    logic [13:0] ga;
    logic [7:0]  gd = 8'd0;
    logic [7:0]  lbaddr;
    logic [7:0]  lbdata;
    logic        lbwe;
    logic        busy;
    logic        done;

    mo_line_writer #(.NOBJ(40)) dut (
        .CLK(clk), .RESETn(rst_n), .START(start), .PLAYER2(player2),
        .OBJA(obja), .OBJD(objd), .SR(sr), .MATCHn(matchn), .ROW(row),
        .GA(ga), .GD(gd), .LBADDR(lbaddr), .LBDATA(lbdata), .LBWE(lbwe),
        .BUSY(busy), .DONE(done)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:127];
    logic [7:0]  rom [0:16383];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    logic [15:0] wq [$];
    logic [13:0] gq [$];
    logic [6:0]  oq [$];
    bit          ga_en = 1'b0;
    bit          oa_en = 1'b0;
    logic [13:0] ga_prev = 14'd0;
    logic [6:0]  oa_prev = 7'd0;

    // Object RAM, picture ROM and vertical control (one register stage)
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        objd   <= ram[obja];
        gd     <= rom[ga];
        matchn <= (sr[15:8] != 8'h80);
        row    <= 4'd5;
    end

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && lbwe) begin
            if (wq.size() == 0) begin
                check(1'b0, "unexpected_write", {lbaddr, lbdata}, 0);
            end else begin
                logic [15:0] e;
                e = wq.pop_front();
                check({lbaddr, lbdata} == e, "lb_write", {lbaddr, lbdata}, e);
            end
        end
        if (rst_n && done) begin
            done_cnt++;
            done_cyc = cyc;
            check(busy == 1'b0, "busy_at_done", busy, 0);
        end
        if (ga_en && ga != ga_prev) begin
            if (gq.size() == 0) begin
                check(1'b0, "unexpected_ga", ga, 0);
            end else begin
                logic [13:0] g;
                g = gq.pop_front();
                check(ga == g, "ga", ga, g);
            end
        end
        ga_prev = ga;
        if (oa_en && obja != oa_prev) begin
            if (oq.size() == 0) begin
                check(1'b0, "unexpected_obja", obja, 0);
            end else begin
                logic [6:0] o;
                o = oq.pop_front();
                check(obja == o, "obja", obja, o);
            end
        end
        oa_prev = obja;
    end

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc, input string name);
        int d0;
        int t;
        d0 = done_cnt;
        t = 0;
        while (done_cnt == d0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        check(done_cnt == d0 + 1, {name, "_seen"}, done_cnt - d0, 1);
        check(done_cyc - start_cyc == exp_cyc, {name, "_time"},
              done_cyc - start_cyc, exp_cyc);
        repeat (5) @(negedge clk);
        check(done_cnt == d0 + 1 && !busy, {name, "_single"},
              {done_cnt - d0, 31'd0, busy}, {32'd1, 32'd0});
    endtask

    task automatic check_queues(input string name);
        check(wq.size() == 0, {name, "_writes_left"}, wq.size(), 0);
        check(gq.size() == 0, {name, "_ga_left"}, gq.size(), 0);
        check(oq.size() == 0, {name, "_obja_left"}, oq.size(), 0);
    endtask

    function automatic logic [55:0] outs();
        return {obja, sr, ga, lbaddr, lbdata, lbwe, busy, done};
    endfunction

    initial begin
        bit busy_seen;
        for (int i = 0; i < 128; i++) ram[i] = 16'd0;
        for (int i = 0; i < 16384; i++) rom[i] = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check(outs() == 56'd0, "reset_outputs", outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check(outs() == 56'd0, "idle_outputs", outs(), 0);

        // No matches: OBJA walks even addresses, DONE after 160 cycles
        for (int i = 1; i < 40; i++) oq.push_back(7'(2 * i));
        oa_en = 1'b1;
        pulse_start();
        check(busy == 1'b1, "busy_rise", busy, 1);
        wait_done(160, "nomatch");
        oa_en = 1'b0;
        check_queues("nomatch");

        // Object 3 matches, normal orientation
        ram[6] = 16'h8012;
        ram[7] = 16'h0A40;
        rom[14'h494] = 8'h12;
        rom[14'h495] = 8'h30;
        rom[14'h496] = 8'h45;
        rom[14'h497] = 8'h67;
        gq = '{14'h494, 14'h495, 14'h496, 14'h497};
        wq = '{16'h40A1, 16'h41A2, 16'h42A3, 16'h44A4,
               16'h45A5, 16'h46A6, 16'h47A7};
        ga_en = 1'b1;
        pulse_start();
        wait_done(178, "obj3");
        check_queues("obj3");

        // Same object, cocktail flip
        player2 = 1'b1;
        gq = '{14'h494, 14'h495, 14'h496, 14'h497};
        wq = '{16'h47A1, 16'h46A2, 16'h45A3, 16'h43A4,
               16'h42A5, 16'h41A6, 16'h40A7};
        pulse_start();
        wait_done(178, "flip");
        ga_en = 1'b0;
        check_queues("flip");

        // Address wrap past 255
        player2 = 1'b0;
        ram[7] = 16'h03FD;
        for (int i = 0; i < 4; i++) rom[14'h494 + i] = 8'h11;
        wq = '{16'hFD31, 16'hFE31, 16'hFF31, 16'h0031,
               16'h0131, 16'h0231, 16'h0331, 16'h0431};
        pulse_start();
        wait_done(178, "wrap");
        check_queues("wrap");

        // Restart during object 5's first GDAT
        ram[6]  = 16'h0012;
        ram[10] = 16'h8021;
        ram[11] = 16'h0510;
        rom[14'h854] = 8'h89;
        rom[14'h855] = 8'hAB;
        rom[14'h856] = 8'hCD;
        rom[14'h857] = 8'hEF;
        wq = '{16'h1058, 16'h1159, 16'h125A, 16'h135B,
               16'h145C, 16'h155D, 16'h165E, 16'h175F};
        pulse_start();
        repeat (27) @(negedge clk);
        check(ga == 14'h854, "abort_ga", ga, 14'h854);
        start = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        check({obja, lbwe, busy} == {7'd0, 1'b0, 1'b1}, "abort_restart",
              {obja, lbwe, busy}, {7'd0, 1'b0, 1'b1});
        wait_done(178, "abort");
        check_queues("abort");

        // Reset during PHI of object 0
        ram[10] = 16'h0021;
        ram[0]  = 16'h8012;
        ram[1]  = 16'h0A40;
        wq = '{16'h40A1};
        pulse_start();
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check(outs() == 56'd0, "reset_midscan", outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        busy_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy || lbwe) busy_seen = 1'b1;
        end
        check(!busy_seen, "idle_after_reset", busy_seen, 0);
        check_queues("reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
